// File: rtl/booth_mult_unit.sv
// Sequential signed WIDTH x WIDTH radix-2 Booth multiplier.
// A start pulse loads the operands, WIDTH iterations run one per clock, and a
// one-cycle ready strobe accompanies the registered product and overflow flag.
module booth_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ctrl_MULT,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [WIDTH-1:0]     data_result,
  output logic [2*WIDTH-1:0]   product,
  output logic                 data_exception,
  output logic                 data_resultRDY,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t             state_reg;
  logic [WIDTH-1:0]   m_reg;
  // One guard bit so that subtracting the most negative M cannot wrap.
  logic [WIDTH:0]     acc_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               q1_reg;
  logic [CW-1:0]      count_reg;

  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     sum_next;
  logic [WIDTH:0]     acc_next;
  logic [WIDTH-1:0]   q_next;
  logic               q1_next;
  logic [2*WIDTH-1:0] product_next;
  logic               exc_next;

  // One Booth step: add/subtract M by {Q[0], q_1}, then arithmetic shift right.
  always_comb begin
    m_ext = {m_reg[WIDTH-1], m_reg};
    case ({q_reg[0], q1_reg})
      2'b01:   sum_next = acc_reg + m_ext;
      2'b10:   sum_next = acc_reg - m_ext;
      default: sum_next = acc_reg;
    endcase
    acc_next     = {sum_next[WIDTH], sum_next[WIDTH:1]};
    q_next       = {sum_next[0], q_reg[WIDTH-1:1]};
    q1_next      = q_reg[0];
    product_next = {acc_next[WIDTH-1:0], q_next};
    // Overflow when the upper half plus the result sign bit are not a pure sign extension.
    exc_next     = !((&product_next[2*WIDTH-1:WIDTH-1]) ||
                     !(|product_next[2*WIDTH-1:WIDTH-1]));
  end

  // Control FSM and datapath; a start pulse wins over every other action.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      m_reg          <= '0;
      acc_reg        <= '0;
      q_reg          <= '0;
      q1_reg         <= 1'b0;
      count_reg      <= '0;
      data_result    <= '0;
      product        <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (ctrl_MULT) begin
      state_reg      <= RUN;
      m_reg          <= multiplicand;
      acc_reg        <= '0;
      q_reg          <= multiplier;
      q1_reg         <= 1'b0;
      count_reg      <= '0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          acc_reg   <= acc_next;
          q_reg     <= q_next;
          q1_reg    <= q1_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST) begin
            state_reg      <= DONE;
            product        <= product_next;
            data_result    <= q_next;
            data_exception <= exc_next;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
          end
        end
        DONE: begin
          state_reg      <= IDLE;
          data_resultRDY <= 1'b0;
        end
        default: begin
          state_reg      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed and randomized checks of booth_mult_unit: results, overflow,
// latency, abort/restart behaviour and asynchronous reset.
module tb_booth_mult_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] data_result;
  logic [63:0] product;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  booth_mult_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .multiplicand   (multiplicand),
    .multiplier     (multiplier),
    .data_result    (data_result),
    .product        (product),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present operands with a one-cycle start pulse; returns just after E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    multiplicand = a;
    multiplier   = b;
    ctrl_MULT    = 1'b1;
    @(negedge clock);
    ctrl_MULT    = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  // Count cycles from the start edge until RDY, noting any busy dropout.
  task automatic wait_done(output int lat, output int busy_drops);
    lat        = -1;
    busy_drops = busy ? 0 : 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        lat = i;
        break;
      end
      if (!busy) busy_drops++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_prod, input logic exp_exc);
    int lat;
    int drops;
    start_op(a, b);
    wait_done(lat, drops);
    check({tag, ".latency"}, 64'(lat), 64'd32);
    check({tag, ".busy_run"}, 64'(drops), 64'd0);
    check({tag, ".busy_end"}, {63'b0, busy}, 64'd0);
    check({tag, ".product"}, product, exp_prod);
    check({tag, ".result"}, {32'b0, data_result}, {32'b0, exp_prod[31:0]});
    check({tag, ".exc"}, {63'b0, data_exception}, {63'b0, exp_exc});
    $display("op %s a=%h b=%h product=%h exc=%b latency=%0d", tag, a, b, product, data_exception, lat);
    @(negedge clock);
    check({tag, ".rdy_drop"}, {63'b0, data_resultRDY}, 64'd0);
  endtask

  initial begin
    int lat;
    int drops;
    int pulses;
    logic [31:0] ra;
    logic [31:0] rb;
    longint pa;
    longint lo;
    longint hi;
    logic exp_exc;

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(negedge clock);
    check("reset.product", product, 64'd0);
    check("reset.result", {32'b0, data_result}, 64'd0);
    check("reset.flags", {61'b0, data_exception, data_resultRDY, busy}, 64'd0);
    reset = 1'b0;

    // Directed vectors.
    run_op("7x-3", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_op("min_x_m1", 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
    run_op("min_x_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
    run_op("pos_ovf", 32'h0001_0000, 32'h0000_8000, 64'h0000_0000_8000_0000, 1'b1);
    run_op("neg_fit", 32'hFFFF_0000, 32'h0000_8000, 64'hFFFF_FFFF_8000_0000, 1'b0);

    // Abort: 5x6 replaced by 9x9 ten cycles in.
    start_op(32'd5, 32'd6);
    pulses = 0;
    repeat (9) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    start_op(32'd9, 32'd9);
    wait_done(lat, drops);
    check("abort.latency", 64'(lat), 64'd32);
    check("abort.result", {32'b0, data_result}, 64'd81);
    repeat (5) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    check("abort.extra_rdy", 64'(pulses), 64'd0);
    $display("op abort 5x6->9x9 result=%0d latency=%0d", data_result, lat);

    // Restart on the final iteration edge: no RDY, prior result kept.
    run_op("3x4", 32'd3, 32'd4, 64'd12, 1'b0);
    start_op(32'd100, 32'd100);
    pulses = 0;
    repeat (31) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    multiplicand = 32'd2;
    multiplier   = 32'd2;
    ctrl_MULT    = 1'b1;
    @(negedge clock);
    ctrl_MULT    = 1'b0;
    if (data_resultRDY) pulses++;
    check("e32.no_rdy", 64'(pulses), 64'd0);
    check("e32.held_product", product, 64'd12);
    check("e32.busy", {63'b0, busy}, 64'd1);
    wait_done(lat, drops);
    check("e32.latency", 64'(lat), 64'd32);
    check("e32.result", product, 64'd4);
    $display("op restart_at_e32 result=%0d latency=%0d", data_result, lat);

    // Start held high for three edges: operation counts from the last one.
    @(negedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b1; multiplicand = 32'd1; multiplier = 32'd1;
    @(negedge clock);
    multiplicand = 32'd2; multiplier = 32'd2;
    @(negedge clock);
    multiplicand = 32'd6; multiplier = 32'd7;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    wait_done(lat, drops);
    check("hold.latency", 64'(lat), 64'd32);
    check("hold.result", product, 64'd42);
    $display("op held_start result=%0d latency=%0d", data_result, lat);
    @(negedge clock);

    // Asynchronous reset mid-run.
    start_op(32'd11, 32'd13);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    #1;
    check("arst.product", product, 64'd0);
    check("arst.result", {32'b0, data_result}, 64'd0);
    check("arst.flags", {61'b0, data_exception, data_resultRDY, busy}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    check("arst.no_rdy", 64'(pulses), 64'd0);
    $display("op reset_mid_run rdy_pulses=%0d", pulses);
    run_op("0xmax", 32'd0, 32'h7FFF_FFFF, 64'd0, 1'b0);

    // Random signed pairs against a 64-bit reference.
    lo = -(longint'(1) <<< 31);
    hi = (longint'(1) <<< 31) - 1;
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 8 == 1) ra = ra >>> 16;
      if (n % 8 == 2) rb = {{16{rb[15]}}, rb[15:0]};
      pa = longint'($signed(ra)) * longint'($signed(rb));
      exp_exc = (pa < lo) || (pa > hi);
      run_op("rand", ra, rb, 64'(pa), exp_exc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/booth_mult_unit.md
Name: booth_mult_unit

Overview:
- Sequential signed 32x32 radix-2 Booth multiplier; the multiply counterpart to the restoring divider in the multdiv path.
- Owns its operand registers, iteration counter, control FSM and overflow check.
- Presents the same start / ready handshake the processor's multdiv stall logic uses for division.
- Sits beside the divider, and its result is muxed onto the shared multdiv result bus.

Parameters:
- WIDTH, 32, operand width in bits; result is WIDTH, product is 2*WIDTH.

Ports:
- clock  in  1  single rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ctrl_MULT  in  1  start pulse, sampled on the rising edge of clock.
- multiplicand  in  WIDTH  signed operand A, sampled only on start.
- multiplier  in  WIDTH  signed operand B, sampled only on start.
- data_result  out  WIDTH  low WIDTH bits of the product.
- product  out  2*WIDTH  full signed product.
- data_exception  out  1  signed overflow: product does not fit in WIDTH bits.
- data_resultRDY  out  1  one-cycle completion strobe.
- busy  out  1  high while iterations are in progress.

Behaviour:
- Reset (async, active-high): FSM=IDLE, counter=0, all datapath registers 0. All outputs 0: data_result, product, data_exception, data_resultRDY, busy.
- FSM states: IDLE, RUN, DONE.
- Start:
  - ctrl_MULT=1 at edge E0, in any state, loads M=multiplicand.
  - Loads the (2*WIDTH+2)-bit register {A[WIDTH:0]=0, Q=multiplier, q_1=0}.
  - Clears counter; FSM->RUN, busy=1.
- RUN, each edge:
  - Inspect {Q[0], q_1}: 01 -> A=A+sext(M); 10 -> A=A-sext(M); 00/11 -> no change.
  - Then arithmetic shift right by 1 of {A,Q,q_1}; A[WIDTH] replicates.
  - Counter increments.
- A is WIDTH+1 bits wide so that M = -2^(WIDTH-1) subtracts without wrap.
- Iterations occur on edges E1..E32. On E32 (counter==WIDTH-1):
  - FSM->DONE.
  - product={A[WIDTH-1:0],Q} registered; data_result=Q.
  - data_exception=1 iff bits [2*WIDTH-1:WIDTH-1] of the product are not all equal.
  - data_resultRDY=1; busy=0.
- DONE:
  - data_resultRDY is high for exactly the one cycle between E32 and E33.
  - At E33: FSM->IDLE, data_resultRDY->0.
- Output hold: product, data_result and data_exception hold their values until the next completion or reset; they are not cleared on start.
- Latency: start at E0, RDY visible after E32. 32 cycles; WIDTH cycles in general.
- ctrl_MULT during RUN: abort the current operation, reload operands, counter=0, no RDY for the aborted op.
- ctrl_MULT on the same edge as the final iteration (E32): restart wins; no RDY; outputs keep their prior values.
- ctrl_MULT during DONE: RDY still drops at that edge; the new operation starts.
- ctrl_MULT held high for several cycles: restarts every edge; the operation begins from the last edge it was high.
- Reset asserted mid-RUN: immediate return to IDLE, outputs 0; no RDY after reset release until a new start.
- Operand inputs may change freely after E0 without affecting the result.

Test Plan:
- Reset, then start with 7 x -3 -> busy high for 32 cycles. RDY pulses once, 32 cycles after start. data_result=0xFFFFFFEB, product=0xFFFFFFFF_FFFFFFEB, exception=0.
- 0x80000000 x 0xFFFFFFFF (-2^31 x -1) -> product=0x00000000_80000000, data_result=0x80000000, exception=1.
- 0x80000000 x 0x80000000 -> product=0x40000000_00000000, exception=1. 0x00010000 x 0x00008000 -> data_result=0x80000000, exception=1. 0xFFFF0000 x 0x00008000 -> data_result=0x80000000, exception=0.
- Start 5 x 6, then re-assert ctrl_MULT with 9 x 9 at cycle 10 -> exactly one RDY, 32 cycles after the second start, data_result=81. Then assert ctrl_MULT on the E32 edge of a run -> no RDY, prior result held.
- Assert reset mid-run at cycle 15 -> all outputs 0 immediately (asynchronously). No RDY for 40 cycles after release. A following 0 x 0x7FFFFFFF run gives result 0, exception 0.
- Randomized signed operand pairs (1000) versus a 64-bit signed reference model: product and exception must match, and RDY must arrive exactly 32 cycles after each start.
